job_supervisor: RTL and testbench



---
 rtl/job_supervisor_pkg.sv | 24 ++
 rtl/job_supervisor_sat.sv | 35 +++
 rtl/job_supervisor.sv | 188 ++++++++++++++++++
 tb/tb_job_supervisor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/job_supervisor_pkg.sv
// Shared definitions for the job supervisor: FSM state encoding, job outcome
// codes and default timing values.
package job_supervisor_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StLaunch   = 3'd1,
      StWaitDone = 3'd2,
      StKill     = 3'd3,
      StRecover  = 3'd4
   } state_e;

   // Outcome of a job, decided on the cycle the job leaves WAIT_DONE.
   typedef enum logic [1:0] {
      OutNone    = 2'd0,
      OutOk      = 2'd1,
      OutAbort   = 2'd2,
      OutTimeout = 2'd3
   } outcome_e;

   localparam int unsigned DefTimeout  = 150;
   localparam int unsigned DefKillHold = 4;

endpackage

// File: rtl/job_supervisor_sat.sv
// sat_counter: CNT_W-bit saturating up-counter.
// Ports:
//   clk_i    clock
//   clr_ni   synchronous active-low clear
//   inc_i    increment enable; ignored once the count is all ones
//   count_o  current count
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/job_supervisor.sv
// job_supervisor: initiator side of a go/kill/done worker handshake.
// Launches jobs on start_req with a one-cycle go pulse, aborts on cancel_req or
// timeout with a held kill level, and reports each outcome with one-cycle
// status pulses and saturating counters. All outputs are registered.
// Ports:
//   clk, reset_n (sync, active low)     clock and reset
//   start_req, cancel_req, done         host requests and worker completion
//   go, kill, busy                      worker controls / activity flag
//   job_ok, job_aborted, job_timeout    per-job outcome pulses
//   busy_err                            pulse when a start request is rejected
//   ok_count, fail_count                saturating outcome counters
// Optional feature macro: JOB_SUPERVISOR_START_QUEUE_EN (one-deep pending start).
module job_supervisor
   import job_supervisor_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned TIMEOUT   = DefTimeout,
   parameter int unsigned KILL_HOLD = DefKillHold,
   parameter int unsigned RECOVER   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_req,
   input  logic             cancel_req,
   input  logic             done,
   output logic             go,
   output logic             kill,
   output logic             busy,
   output logic             job_ok,
   output logic             job_aborted,
   output logic             job_timeout,
   output logic             busy_err,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] fail_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   outcome_e         outcome;
   logic             reject;
   logic             go_q, kill_q, busy_q, ok_q, abort_q, timeout_q, busy_err_q;
   logic             ok_inc, fail_inc;

`ifdef JOB_SUPERVISOR_START_QUEUE_EN
   logic pend_q, pend_d;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      outcome = OutNone;
      reject  = 1'b0;
`ifdef JOB_SUPERVISOR_START_QUEUE_EN
      pend_d  = pend_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef JOB_SUPERVISOR_START_QUEUE_EN
            if (start_req || pend_q) begin
               pend_d = 1'b0;
`else
            if (start_req) begin
`endif
               state_d = StLaunch;
               timer_d = '0;
            end
         end
         // Timer is 0 while go is high, so it counts cycles since go.
         StLaunch: begin
            state_d = StWaitDone;
            timer_d = timer_q + 1'b1;
         end
         StWaitDone: begin
            if (done) begin
               outcome = OutOk;
               state_d = StIdle;
            end else if (cancel_req) begin
               outcome = OutAbort;
               state_d = StKill;
               timer_d = '0;
            end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
               outcome = OutTimeout;
               state_d = StKill;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StKill: begin
            if (timer_q == CNT_W'(KILL_HOLD - 1)) begin
               state_d = (RECOVER == 0) ? StIdle : StRecover;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRecover: begin
            if (timer_q == CNT_W'(RECOVER - 1)) begin
               state_d = StIdle;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase

      if (start_req && (state_q != StIdle)) begin
`ifdef JOB_SUPERVISOR_START_QUEUE_EN
         if (pend_q) begin
            reject = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
`else
         reject = 1'b1;
`endif
      end
   end

   // Outputs are flopped from next-state decode so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         go_q       <= 1'b0;
         kill_q     <= 1'b0;
         busy_q     <= 1'b0;
         ok_q       <= 1'b0;
         abort_q    <= 1'b0;
         timeout_q  <= 1'b0;
         busy_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         go_q       <= (state_d == StLaunch);
         kill_q     <= (state_d == StKill);
         busy_q     <= (state_d != StIdle);
         ok_q       <= (outcome == OutOk);
         abort_q    <= (outcome == OutAbort);
         timeout_q  <= (outcome == OutTimeout);
         busy_err_q <= reject;
      end
   end

`ifdef JOB_SUPERVISOR_START_QUEUE_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end
`endif

   assign ok_inc   = (outcome == OutOk);
   assign fail_inc = (outcome == OutAbort) || (outcome == OutTimeout);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_ok_cnt (
      .clk_i   (clk),
      .clr_ni  (reset_n),
      .inc_i   (ok_inc),
      .count_o (ok_count)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_fail_cnt (
      .clk_i   (clk),
      .clr_ni  (reset_n),
      .inc_i   (fail_inc),
      .count_o (fail_count)
   );

   assign go          = go_q;
   assign kill        = kill_q;
   assign busy        = busy_q;
   assign job_ok      = ok_q;
   assign job_aborted = abort_q;
   assign job_timeout = timeout_q;
   assign busy_err    = busy_err_q;

endmodule

// File: tb/tb_job_supervisor.sv
// Scoreboard bench for job_supervisor. Stimulus pushes the expected output
// changes (cycle, status vector, counters); the monitor pops and compares
// whenever any output changes or a snapshot is requested.
// Status vector bit order: {go, kill, busy, job_ok, job_aborted, job_timeout, busy_err}.
module tb_job_supervisor;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset_n, start_req, cancel_req, done;
   logic             go, kill, busy, job_ok, job_aborted, job_timeout, busy_err;
   logic [CNT_W-1:0] ok_count, fail_count;

   job_supervisor #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (150),
      .KILL_HOLD (4),
      .RECOVER   (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_req   (start_req),
      .cancel_req  (cancel_req),
      .done        (done),
      .go          (go),
      .kill        (kill),
      .busy        (busy),
      .job_ok      (job_ok),
      .job_aborted (job_aborted),
      .job_timeout (job_timeout),
      .busy_err    (busy_err),
      .ok_count    (ok_count),
      .fail_count  (fail_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               c;
      logic [6:0]       v;
      logic [CNT_W-1:0] okc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;
   logic snap_req = 1'b0;
   logic final_req = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push(input int c, input logic [6:0] v, input int okc, input int fc);
      exp_t e;
      e.c   = c;
      e.v   = v;
      e.okc = CNT_W'(okc);
      e.fc  = CNT_W'(fc);
      exp_q.push_back(e);
   endtask

   // Monitor: compares each observed output change against the queue front.
   logic [6:0]       obs, prev_obs;
   logic [CNT_W-1:0] prev_ok, prev_fail;
   exp_t             ev;
   always @(negedge clk) begin
      if (mon_en) begin
         obs = {go, kill, busy, job_ok, job_aborted, job_timeout, busy_err};
         while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: expected at cycle %0d vec=%b ok=%0d fail=%0d, not observed",
                     ev.c, ev.v, ev.okc, ev.fc);
         end
         if (snap_req || obs != prev_obs || ok_count != prev_ok || fail_count != prev_fail) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: cycle %0d vec=%b ok=%0d fail=%0d, nothing expected",
                        cyc, obs, ok_count, fail_count);
            end else begin
               ev = exp_q.pop_front();
               if (ev.c != cyc || ev.v != obs || ev.okc != ok_count || ev.fc != fail_count) begin
                  errors++;
                  $display("FAIL event: got cycle %0d vec=%b ok=%0d fail=%0d, want cycle %0d vec=%b ok=%0d fail=%0d",
                           cyc, obs, ok_count, fail_count, ev.c, ev.v, ev.okc, ev.fc);
               end
            end
         end
         if (final_req) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL drain: %0d expected events left, want 0", exp_q.size());
            end
         end
         prev_obs  = obs;
         prev_ok   = ok_count;
         prev_fail = fail_count;
      end
   end

   // One job that the worker finishes 10 cycles after go.
   task automatic run_ok_job(input int okc, input int fc);
      int c0;
      c0 = cyc;
      push(c0 + 1,  7'b1010000, okc, fc);
      push(c0 + 2,  7'b0010000, okc, fc);
      push(c0 + 12, 7'b0001000, okc + 1, fc);
      push(c0 + 13, 7'b0000000, okc + 1, fc);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 11);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 16);
   endtask

   int c0;
   int okc;
   initial begin
      reset_n = 1'b0; start_req = 1'b0; cancel_req = 1'b0; done = 1'b0;
      prev_obs = '0; prev_ok = '0; prev_fail = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      mon_en = 1'b1;

      // Reset state snapshot.
      push(cyc, 7'b0000000, 0, 0);
      snap_req = 1'b1; tick(); snap_req = 1'b0;
      tick();

      // Normal completion.
      run_ok_job(0, 0);

      // Timeout: worker never answers.
      c0 = cyc;
      push(c0 + 1,   7'b1010000, 1, 0);
      push(c0 + 2,   7'b0010000, 1, 0);
      push(c0 + 151, 7'b0110010, 1, 1);
      push(c0 + 152, 7'b0110000, 1, 1);
      push(c0 + 155, 7'b0010000, 1, 1);
      push(c0 + 157, 7'b0000000, 1, 1);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 160);

      // Cancel 20 cycles after go; done during KILL and cancel during RECOVER are ignored.
      c0 = cyc;
      push(c0 + 1,  7'b1010000, 1, 1);
      push(c0 + 2,  7'b0010000, 1, 1);
      push(c0 + 22, 7'b0110100, 1, 2);
      push(c0 + 23, 7'b0110000, 1, 2);
      push(c0 + 26, 7'b0010000, 1, 2);
      push(c0 + 28, 7'b0000000, 1, 2);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 21);
      cancel_req = 1'b1; tick(); cancel_req = 1'b0;
      wait_until(c0 + 23);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 26);
      cancel_req = 1'b1; tick(); cancel_req = 1'b0;
      wait_until(c0 + 31);

      // done and cancel together: done wins; later done in IDLE is ignored.
      c0 = cyc;
      push(c0 + 1, 7'b1010000, 1, 2);
      push(c0 + 2, 7'b0010000, 1, 2);
      push(c0 + 7, 7'b0001000, 2, 2);
      push(c0 + 8, 7'b0000000, 2, 2);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 6);
      done = 1'b1; cancel_req = 1'b1; tick(); done = 1'b0; cancel_req = 1'b0;
      wait_until(c0 + 9);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 12);

      // Second start request 5 cycles into a job.
      c0 = cyc;
`ifdef JOB_SUPERVISOR_START_QUEUE_EN
      push(c0 + 1,  7'b1010000, 2, 2);
      push(c0 + 2,  7'b0010000, 2, 2);
      push(c0 + 8,  7'b0010001, 2, 2);
      push(c0 + 9,  7'b0010000, 2, 2);
      push(c0 + 12, 7'b0001000, 3, 2);
      push(c0 + 13, 7'b1010000, 3, 2);
      push(c0 + 14, 7'b0010000, 3, 2);
      push(c0 + 21, 7'b0001000, 4, 2);
      push(c0 + 22, 7'b0000000, 4, 2);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 6);
      // First extra request is queued, the second is rejected.
      start_req = 1'b1; tick(); tick(); start_req = 1'b0;
      wait_until(c0 + 11);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 20);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 26);
      okc = 4;
`else
      push(c0 + 1,  7'b1010000, 2, 2);
      push(c0 + 2,  7'b0010000, 2, 2);
      push(c0 + 7,  7'b0010001, 2, 2);
      push(c0 + 8,  7'b0010000, 2, 2);
      push(c0 + 12, 7'b0001000, 3, 2);
      push(c0 + 13, 7'b0000000, 3, 2);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 6);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 11);
      done = 1'b1; tick(); done = 1'b0;
      wait_until(c0 + 20);
      okc = 3;
`endif

      // Reset mid-WAIT_DONE clears everything, then a fresh job runs normally.
      c0 = cyc;
      push(c0 + 1, 7'b1010000, okc, 2);
      push(c0 + 2, 7'b0010000, okc, 2);
      push(c0 + 6, 7'b0000000, 0, 0);
      start_req = 1'b1; tick(); start_req = 1'b0;
      wait_until(c0 + 5);
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      wait_until(c0 + 8);
      run_ok_job(0, 0);

      final_req = 1'b1; tick(); final_req = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
